// File: rtl/ipml_sync_fifo_fwft_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// slave: FIFO side, master: user side.
interface ipml_sync_fifo_fwft_if #(
    parameter int unsigned c_DEPTH_WIDTH = 10,
    parameter int unsigned c_DATA_WIDTH  = 32
);
    logic [c_DATA_WIDTH-1:0]  wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic [c_DATA_WIDTH-1:0]  rd_data;
    logic                     rd_en;
    logic                     rd_empty;
    logic                     almost_empty;
    logic [c_DEPTH_WIDTH:0]   water_level;
    logic                     overflow;
    logic                     underflow;

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );
endinterface

// File: rtl/ipml_sync_fifo_fwft.sv
// Single-clock FIFO with water level, almost flags and optional FWFT prefetch.
// Sticky overflow/underflow logic only exists when IPML_FIFO_ERR_FLAG_EN is defined.
module ipml_sync_fifo_fwft #(
    parameter int unsigned c_DEPTH_WIDTH      = 10,
    parameter int unsigned c_DATA_WIDTH       = 32,
    parameter int unsigned c_FWFT             = 0,
    parameter int unsigned c_ALMOST_FULL_NUM  = 1020,
    parameter int unsigned c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ipml_sync_fifo_fwft_if.slave   fifo
);
    localparam int unsigned AW     = c_DEPTH_WIDTH;
    localparam int unsigned DW     = c_DATA_WIDTH;
    localparam int unsigned CAP    = 32'(1) << AW;
    localparam int unsigned AF_EFF = (c_ALMOST_FULL_NUM > CAP) ? CAP : c_ALMOST_FULL_NUM;

    typedef logic [AW:0] lvl_t;

    logic [DW-1:0] mem [CAP];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    lvl_t          level_q, level_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          wr_full_q, wr_full_d, almost_full_q, almost_full_d;
    logic          rd_empty_q, rd_empty_d, almost_empty_q, almost_empty_d;
    logic          wr_acc_c, rd_acc_c, load_c;

    // Accept decisions, pointer/level update and registered read path.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rd_data_d      = rd_data_q;
        rd_empty_d     = rd_empty_q;
        wr_acc_c       = fifo.wr_en && !wr_full_q;
        rd_acc_c       = fifo.rd_en && !rd_empty_q;
        load_c         = 1'b0;
        level_d        = level_q + lvl_t'(wr_acc_c) - lvl_t'(rd_acc_c);

        if (wr_acc_c) wr_ptr_d = wr_ptr_q + 1'b1;

        if (c_FWFT != 0) begin
            // Memory holds level minus the prefetched head; refill when head is free.
            load_c     = (level_q > lvl_t'(!rd_empty_q)) && (rd_empty_q || rd_acc_c);
            rd_empty_d = !(load_c || (!rd_empty_q && !rd_acc_c));
        end else begin
            load_c     = rd_acc_c;
            rd_empty_d = (level_d == '0);
        end

        if (load_c) begin
            rd_data_d = mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        wr_full_d      = (level_d == lvl_t'(CAP));
        almost_full_d  = (level_d >= lvl_t'(AF_EFF));
        almost_empty_d = (level_d <= lvl_t'(c_ALMOST_EMPTY_NUM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            rd_data_q      <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            rd_data_q      <= rd_data_d;
            wr_full_q      <= wr_full_d;
            almost_full_q  <= almost_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) mem[wr_ptr_q] <= fifo.wr_data;
    end

`ifdef IPML_FIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (fifo.wr_en & wr_full_q);
        underflow_d = underflow_q | (fifo.rd_en & rd_empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`else
    assign fifo.overflow  = 1'b0;
    assign fifo.underflow = 1'b0;
`endif

    assign fifo.wr_full      = wr_full_q;
    assign fifo.almost_full  = almost_full_q;
    assign fifo.rd_data      = rd_data_q;
    assign fifo.rd_empty     = rd_empty_q;
    assign fifo.almost_empty = almost_empty_q;
    assign fifo.water_level  = level_q;
endmodule

// File: tb/tb_ipml_sync_fifo_fwft.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO share one random stimulus
// stream; a queue/timestamp reference model predicts levels, flags and read data.
module tb_ipml_sync_fifo_fwft;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 8;
    localparam int          CAP = 16;
    localparam int          AF  = 14;
    localparam int          AE  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ipml_sync_fifo_fwft_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) if0 ();
    ipml_sync_fifo_fwft_if #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)) if1 ();

    assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;  assign if0.wr_data = wr_data;
    assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;  assign if1.wr_data = wr_data;

    ipml_sync_fifo_fwft #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(0),
                          .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE))
        u_std (.clk(clk), .rst(rst), .fifo(if0));

    ipml_sync_fifo_fwft #(.c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_FWFT(1),
                          .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE))
        u_fwft (.clk(clk), .rst(rst), .fifo(if1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: std words are readable once held; FWFT head is visible
    // only from the edge after the one that wrote it.
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    int            ts1[$];
    int            lvl0 = 0, ecnt = 0, prev = 0;
    bit            ovf0 = 0, unf0 = 0, ovf1 = 0, unf1 = 0, vis = 0, e1 = 1;
    bit            wa, ra;

    always @(posedge clk) begin
        prev = ecnt;
        ecnt = ecnt + 1;
        if (rst) begin
            lvl0 = 0; ts1.delete();
            ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0; e1 = 1;
        end else begin
            if (wr_en && lvl0 == CAP) ovf0 = 1;
            if (rd_en && lvl0 == 0)   unf0 = 1;
            wa = wr_en && (lvl0 < CAP);
            ra = rd_en && (lvl0 > 0);
            if (wa) sb0.push_back(wr_data);
            lvl0 = lvl0 + int'(wa) - int'(ra);

            vis = (ts1.size() > 0) && (ts1[0] <= prev - 1);
            if (wr_en && ts1.size() == CAP) ovf1 = 1;
            if (rd_en && !vis) unf1 = 1;
            wa = wr_en && (ts1.size() < CAP);
            ra = rd_en && vis;
            if (ra) void'(ts1.pop_front());
            if (wa) begin
                ts1.push_back(ecnt);
                sb1.push_back(wr_data);
            end
            e1 = !((ts1.size() > 0) && (ts1[0] <= ecnt - 1));
        end
    end

    // Standard-mode monitor: data appears the cycle after an accepted read.
    logic [DW-1:0] last0 = '0;
    bit hs0, rs0;
    always @(posedge clk) begin
        hs0 = !rst && rd_en && !if0.rd_empty;
        rs0 = rst;
        @(negedge clk);
        if (rs0) begin
            sb0.delete();
            last0 = '0;
        end else if (hs0) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL std_sb_underrun: got read, expected none");
            end else begin
                last0 = sb0.pop_front();
            end
        end
        chk("std_rd_data", 32'(if0.rd_data), 32'(last0));
    end

    // FWFT monitor: head word is checked when popped and whenever it is shown.
    always @(posedge clk) begin
        if (rst) begin
            sb1.delete();
        end else if (rd_en && !if1.rd_empty) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL fwft_sb_underrun: got pop, expected none");
            end else begin
                chk("fwft_pop_data", 32'(if1.rd_data), 32'(sb1[0]));
                void'(sb1.pop_front());
            end
        end
        @(negedge clk);
        if (!e1 && sb1.size() > 0) chk("fwft_head", 32'(if1.rd_data), 32'(sb1[0]));
    end

    // Level and flag checker.
    bit eo0, eu0, eo1, eu1;
    int lvl1;
    always @(negedge clk) begin
`ifdef IPML_FIFO_ERR_FLAG_EN
        eo0 = ovf0; eu0 = unf0; eo1 = ovf1; eu1 = unf1;
`else
        eo0 = 0; eu0 = 0; eo1 = 0; eu1 = 0;
`endif
        lvl1 = ts1.size();
        chk("std_level",     32'(if0.water_level),  32'(lvl0));
        chk("std_full",      32'(if0.wr_full),      32'(lvl0 == CAP));
        chk("std_empty",     32'(if0.rd_empty),     32'(lvl0 == 0));
        chk("std_afull",     32'(if0.almost_full),  32'(lvl0 >= AF));
        chk("std_aempty",    32'(if0.almost_empty), 32'(lvl0 <= AE));
        chk("std_overflow",  32'(if0.overflow),     32'(eo0));
        chk("std_underflow", 32'(if0.underflow),    32'(eu0));
        chk("fwft_level",    32'(if1.water_level),  32'(lvl1));
        chk("fwft_full",     32'(if1.wr_full),      32'(lvl1 == CAP));
        chk("fwft_empty",    32'(if1.rd_empty),     32'(e1));
        chk("fwft_afull",    32'(if1.almost_full),  32'(lvl1 >= AF));
        chk("fwft_aempty",   32'(if1.almost_empty), 32'(lvl1 <= AE));
        chk("fwft_overflow", 32'(if1.overflow),     32'(eo1));
        chk("fwft_underflow",32'(if1.underflow),    32'(eu1));
    end

    task automatic tick(input bit r, input bit we, input logic [DW-1:0] d, input bit re);
        rst = r; wr_en = we; wr_data = d; rd_en = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw, pr;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        if (if0.water_level != 0 || if1.rd_data != 0)
            $display("note: reset state checked by monitors");
        // Fill 16 plus one rejected write, then drain with one extra read.
        for (int i = 0; i < 17; i++) tick(0, 1, DW'(i), 0);
        for (int i = 0; i < 17; i++) tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        // Single-word fall-through latency.
        tick(0, 1, 8'hA5, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        // Steady state at level 8 across pointer wrap.
        for (int i = 0; i < 8; i++)   tick(0, 1, DW'($urandom), 0);
        for (int i = 0; i < 100; i++) tick(0, 1, DW'($urandom), 1);
        // Simultaneous access at empty and at full.
        for (int i = 0; i < 20; i++)  tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 1, DW'($urandom), 1);
        for (int i = 0; i < 15; i++)  tick(0, 1, DW'($urandom), 0);
        tick(0, 0, 0, 0);
        tick(0, 1, DW'($urandom), 1);
        tick(0, 0, 0, 0);
        // Reset mid-stream at level 9 with both requests active.
        for (int i = 0; i < 20; i++)  tick(0, 0, 0, 1);
        for (int i = 0; i < 9; i++)   tick(0, 1, DW'($urandom), 0);
        tick(1, 1, DW'($urandom), 1);
        tick(0, 1, DW'($urandom), 0);
        tick(0, 0, 0, 0);
        // Random traffic with shifting write/read bias and rare resets.
        for (int b = 0; b < 4; b++) begin
            pw = 30 + 20 * b;
            pr = 90 - 20 * b;
            for (int i = 0; i < 100; i++)
                tick($urandom_range(0, 149) == 0,
                     $urandom_range(0, 99) < pw,
                     DW'($urandom),
                     $urandom_range(0, 99) < pr);
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
